// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: FSM state encoding and MIPS opcode
// constants used when building instruction words.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/instr_fifo.sv
// In-order instruction queue with a registered ready flag and occupancy count.
// A pop never frees a slot for a push in the same cycle.
module instr_fifo #(
  parameter int unsigned IW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   push_valid_i,
  input  logic [IW-1:0]          push_data_i,
  output logic                   push_ready_o,
  input  logic                   pop_i,
  output logic [IW-1:0]          head_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          rdy_q;
  logic          do_push, do_pop;

  assign do_push = push_valid_i & rdy_q;
  assign do_pop  = pop_i & (level_q != '0);

  always_comb begin
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  // Ready is registered from the next level so it always reflects the stored occupancy.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      rdy_q   <= (level_d != LW'(DEPTH));
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign push_ready_o = rdy_q;
  assign head_o       = mem_q[rd_ptr_q];
  assign level_o      = level_q;

endmodule

// File: rtl/instr_sequencer.sv
// Cycle-exact instruction feeder for mipscpu: queues host words and issues one every
// ISSUE_GAP cycles. Optional single-step HOLD state when SEQ_STEP_EN is defined.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned IW        = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ISSUE_GAP = 6
) (
  input  logic                   Clk,
  input  logic                   Reset,
`ifdef SEQ_STEP_EN
  input  logic                   step,
`endif
  input  logic                   pushValid,
  input  logic [IW-1:0]          pushInstr,
  output logic                   pushReady,
  input  logic                   run,
  output logic [IW-1:0]          instrWord,
  output logic                   newInstr,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             issued,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned GW = $clog2(ISSUE_GAP);

  state_e        state_q;
  logic [GW-1:0] cnt_q;
  logic [IW-1:0] word_q;
  logic          new_q, done_q;
  logic [7:0]    issued_q;
  logic [IW-1:0] head;
  logic          go_issue, go_done;

  instr_fifo #(.IW(IW), .DEPTH(DEPTH)) u_fifo (
    .Clk          (Clk),
    .Reset        (Reset),
    .push_valid_i (pushValid),
    .push_data_i  (pushInstr),
    .push_ready_o (pushReady),
    .pop_i        (state_q == ISSUE),
    .head_o       (head),
    .level_o      (level)
  );

  // End-of-gap decision, shared by WAIT expiry and a HOLD step.
  always_comb begin
    go_issue = run && (level != '0);
    go_done  = run && (level == '0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      new_q    <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= '0;
    end else begin
      new_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_issue) state_q <= ISSUE;
        end
        ISSUE: begin
          word_q   <= head;
          new_q    <= 1'b1;
          cnt_q    <= GW'(ISSUE_GAP - 1);
          issued_q <= issued_q + 8'd1;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (cnt_q == GW'(1)) begin
`ifdef SEQ_STEP_EN
            state_q <= HOLD;
`else
            state_q <= go_issue ? ISSUE : IDLE;
            done_q  <= go_done;
`endif
          end else begin
            cnt_q <= cnt_q - GW'(1);
          end
        end
        HOLD: begin
`ifdef SEQ_STEP_EN
          if (step) begin
            state_q <= go_issue ? ISSUE : IDLE;
            done_q  <= go_done;
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instrWord = word_q;
  assign newInstr  = new_q;
  assign done      = done_q;
  assign issued    = issued_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, basic program, full queue, mid-stream
// reset, late push and (with SEQ_STEP_EN) single-stepping.
module tb_instr_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, pushValid, run, step;
  logic [31:0] pushInstr;
  logic        pushReady, newInstr, busy, done;
  logic [31:0] instrWord;
  logic [7:0]  issued;
  logic [3:0]  level;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_word = 32'h0;

  always #5 Clk = ~Clk;

  instr_sequencer #(.IW(32), .DEPTH(8), .ISSUE_GAP(6)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
`ifdef SEQ_STEP_EN
    .step      (step),
`endif
    .pushValid (pushValid),
    .pushInstr (pushInstr),
    .pushReady (pushReady),
    .run       (run),
    .instrWord (instrWord),
    .newInstr  (newInstr),
    .busy      (busy),
    .done      (done),
    .issued    (issued),
    .level     (level)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    pushValid = 1'b1;
    pushInstr = w;
    tick();
    pushValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; run = 1'b0; step = 1'b0;
    pushValid = 1'b1; pushInstr = 32'hDEADBEEF;
    tick(); tick();
    vectors++; if (pushReady !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", pushReady); end
    vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
    vectors++; if (newInstr !== 1'b0) begin miscompares++; $display("FAIL reset_new got %b want 0", newInstr); end
    vectors++; if (instrWord !== 32'h0) begin miscompares++; $display("FAIL reset_word got %h want 0", instrWord); end
    vectors++; if (issued !== 8'd0) begin miscompares++; $display("FAIL reset_issued got %0d want 0", issued); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    pushValid = 1'b0;
    Reset = 1'b1;
    tick();
    vectors++; if (pushReady !== 1'b1 || level !== 4'd0) begin miscompares++; $display("FAIL reset_release got rdy=%b lvl=%0d want rdy=1 lvl=0", pushReady, level); end
  endtask

  task automatic test_basic();
    logic [31:0] prog [6];
    logic        exp_new;
    prog[0] = 32'h8C010000; prog[1] = 32'h8C020001; prog[2] = 32'h8C030002;
    prog[3] = 32'h00222020; prog[4] = 32'h00832822; prog[5] = 32'hAC050003;
    for (int i = 0; i < 6; i++) push(prog[i]);
    vectors++; if (level !== 4'd6) begin miscompares++; $display("FAIL basic_level got %0d want 6", level); end
    run = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      exp_new = (c >= 2) && ((c - 2) % 6 == 0) && ((c - 2) / 6 < 6);
      if (exp_new) exp_word = prog[(c - 2) / 6];
      vectors++; if (newInstr !== exp_new) begin miscompares++; $display("FAIL basic_new c=%0d got %b want %b", c, newInstr, exp_new); end
      vectors++; if (instrWord !== exp_word) begin miscompares++; $display("FAIL basic_word c=%0d got %h want %h", c, instrWord, exp_word); end
      vectors++; if (done !== (c == 37)) begin miscompares++; $display("FAIL basic_done c=%0d got %b want %b", c, done, (c == 37)); end
      vectors++; if (busy !== (c < 37)) begin miscompares++; $display("FAIL basic_busy c=%0d got %b want %b", c, busy, (c < 37)); end
    end
    run = 1'b0;
    vectors++; if (issued !== 8'd6) begin miscompares++; $display("FAIL basic_issued got %0d want 6", issued); end
    vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL basic_drained got %0d want 0", level); end
  endtask

  task automatic test_full();
    logic exp_new;
    for (int i = 0; i < 8; i++) push(32'h1000_0000 + 32'(i));
    vectors++; if (level !== 4'd8 || pushReady !== 1'b0) begin miscompares++; $display("FAIL full_8 got lvl=%0d rdy=%b want lvl=8 rdy=0", level, pushReady); end
    push(32'h1000_0008);
    vectors++; if (level !== 4'd8 || pushReady !== 1'b0) begin miscompares++; $display("FAIL full_9th got lvl=%0d rdy=%b want lvl=8 rdy=0", level, pushReady); end
    run = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      tick();
      exp_new = (c >= 2) && ((c - 2) % 6 == 0) && ((c - 2) / 6 < 8);
      if (exp_new) exp_word = 32'h1000_0000 + 32'((c - 2) / 6);
      vectors++; if (newInstr !== exp_new) begin miscompares++; $display("FAIL full_new c=%0d got %b want %b", c, newInstr, exp_new); end
      vectors++; if (instrWord !== exp_word) begin miscompares++; $display("FAIL full_word c=%0d got %h want %h", c, instrWord, exp_word); end
      vectors++; if (done !== (c == 49)) begin miscompares++; $display("FAIL full_done c=%0d got %b want %b", c, done, (c == 49)); end
    end
    run = 1'b0;
    vectors++; if (issued !== 8'd14 || level !== 4'd0) begin miscompares++; $display("FAIL full_end got iss=%0d lvl=%0d want iss=14 lvl=0", issued, level); end
  endtask

  task automatic test_midreset();
    logic exp_new;
    push(32'h2000_0000); push(32'h2000_0001); push(32'h2000_0002);
    run = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      exp_new = (c == 2) || (c == 8);
      if (c == 2) exp_word = 32'h2000_0000;
      if (c == 8) exp_word = 32'h2000_0001;
      if (c >= 11) exp_word = 32'h0;
      vectors++; if (newInstr !== exp_new) begin miscompares++; $display("FAIL midrst_new c=%0d got %b want %b", c, newInstr, exp_new); end
      vectors++; if (instrWord !== exp_word) begin miscompares++; $display("FAIL midrst_word c=%0d got %h want %h", c, instrWord, exp_word); end
      if (c == 10) begin Reset = 1'b0; run = 1'b0; end
      if (c == 11) begin
        vectors++; if (level !== 4'd0 || issued !== 8'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_state got lvl=%0d iss=%0d busy=%b want 0 0 0", level, issued, busy); end
      end
    end
    Reset = 1'b1;
    tick();
    vectors++; if (pushReady !== 1'b1 || level !== 4'd0) begin miscompares++; $display("FAIL midrst_release got rdy=%b lvl=%0d want rdy=1 lvl=0", pushReady, level); end
    run = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (busy !== 1'b0 || newInstr !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrst_empty got busy=%b new=%b done=%b want 000", busy, newInstr, done); end
    end
    run = 1'b0;
  endtask

  task automatic test_late_push();
    logic exp_new;
    push(32'h3000_00AA);
    run = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      exp_new = (c == 2) || (c == 8);
      if (c == 2) exp_word = 32'h3000_00AA;
      if (c == 8) exp_word = 32'h3000_00BB;
      vectors++; if (newInstr !== exp_new) begin miscompares++; $display("FAIL late_new c=%0d got %b want %b", c, newInstr, exp_new); end
      vectors++; if (instrWord !== exp_word) begin miscompares++; $display("FAIL late_word c=%0d got %h want %h", c, instrWord, exp_word); end
      vectors++; if (done !== (c == 13)) begin miscompares++; $display("FAIL late_done c=%0d got %b want %b", c, done, (c == 13)); end
      if (c == 2) begin pushValid = 1'b1; pushInstr = 32'h3000_00BB; end
      if (c == 3) pushValid = 1'b0;
    end
    run = 1'b0;
    vectors++; if (issued !== 8'd2) begin miscompares++; $display("FAIL late_issued got %0d want 2", issued); end
  endtask

`ifdef SEQ_STEP_EN
  task automatic test_step();
    push(32'h4000_0001); push(32'h4000_0002);
    run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      vectors++; if (newInstr !== (c == 2) || done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL step_hold1 c=%0d got new=%b done=%b busy=%b", c, newInstr, done, busy); end
    end
    step = 1'b1; tick(); step = 1'b0;
    vectors++; if (newInstr !== 1'b0) begin miscompares++; $display("FAIL step_issue got %b want 0", newInstr); end
    tick();
    vectors++; if (newInstr !== 1'b1 || instrWord !== 32'h4000_0002) begin miscompares++; $display("FAIL step_second got new=%b word=%h want 1 40000002", newInstr, instrWord); end
    for (int c = 0; c < 15; c++) begin
      tick();
      vectors++; if (newInstr !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL step_hold2 c=%0d got new=%b done=%b busy=%b", c, newInstr, done, busy); end
    end
    step = 1'b1; tick(); step = 1'b0;
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL step_done got done=%b busy=%b want 1 0", done, busy); end
    step = 1'b1; tick(); step = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || issued !== 8'd4) begin miscompares++; $display("FAIL step_idle got busy=%b done=%b iss=%0d want 0 0 4", busy, done, issued); end
    run = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_midreset();
    test_late_push();
`ifdef SEQ_STEP_EN
    test_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
